// File: rtl/ql_mem_pkg.sv
// Shared types and defaults for the SDRAM port arbiter between the 68008 bus and the ioctl loader.
package ql_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        CPU_WR = 2'd2,
        LD_WR  = 2'd3
    } state_t;

    localparam logic [23:0] LD_BASE_DEF     = 24'h010000;
    localparam int unsigned LD_MAX_SKIP_DEF = 4;
    localparam int unsigned RD_LAT_DEF      = 6;
    localparam logic [8:0]  VRAM_PAGE_DEF   = 9'd2;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic [1:0]  ds;
        logic        we;
    } mem_req_t;

    function automatic logic in_page(input logic [23:0] addr, input logic [8:0] page);
        return addr[23:15] == page;
    endfunction

endpackage

// File: rtl/ql_ram_arbiter_if.sv
// CPU, loader and SDRAM-side signals of the RAM arbiter; slave is the arbiter view.
interface ql_ram_arbiter_if;

    logic        slot;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [1:0]  cpu_ds;
    logic [15:0] cpu_dout;
    logic        cpu_stall;
    logic        ld_wr;
    logic [23:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_wait;
    logic [23:0] sdram_addr;
    logic [15:0] sdram_din;
    logic        sdram_we;
    logic        sdram_oe;
    logic [1:0]  sdram_ds;
    logic [15:0] sdram_dout;
    logic        vram_we;

    modport slave (
        input  slot, cpu_rd, cpu_wr, cpu_addr, cpu_din, cpu_ds,
        input  ld_wr, ld_addr, ld_data, sdram_dout,
        output cpu_dout, cpu_stall, ld_wait,
        output sdram_addr, sdram_din, sdram_we, sdram_oe, sdram_ds, vram_we
    );

    modport master (
        output slot, cpu_rd, cpu_wr, cpu_addr, cpu_din, cpu_ds,
        output ld_wr, ld_addr, ld_data, sdram_dout,
        input  cpu_dout, cpu_stall, ld_wait,
        input  sdram_addr, sdram_din, sdram_we, sdram_oe, sdram_ds, vram_we
    );

endinterface

// File: rtl/ql_ld_buffer.sv
// One-entry holding register for loader words; full doubles as the ioctl_wait throttle.
module ql_ld_buffer
    import ql_mem_pkg::*;
#(
    parameter logic [23:0] LD_BASE = LD_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_wr,
    input  logic [23:0] ld_addr,
    input  logic [15:0] ld_data,
    input  logic        take,
    output logic        full,
    output mem_req_t    entry
);

    // A write arriving while full is dropped, including on the edge that drains the entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (take) begin
            full <= 1'b0;
        end else if (ld_wr && !full) begin
            full  <= 1'b1;
            entry <= '{addr: LD_BASE + ld_addr, data: ld_data, ds: 2'b11, we: 1'b1};
        end
    end

endmodule

// File: rtl/ql_ram_arbiter.sv
// Sequences one SDRAM access per slot between the CPU and the loader, stalls the CPU when it
// loses a slot or waits for read data, and mirrors screen-window writes to VRAM.
module ql_ram_arbiter
    import ql_mem_pkg::*;
#(
    parameter logic [23:0] LD_BASE     = LD_BASE_DEF,
    parameter int unsigned LD_MAX_SKIP = LD_MAX_SKIP_DEF,
    parameter int unsigned RD_LAT      = RD_LAT_DEF,
    parameter logic [8:0]  VRAM_PAGE   = VRAM_PAGE_DEF
) (
    input  logic            clk_sys,
    input  logic            reset,
    ql_ram_arbiter_if.slave bus
);

    localparam int unsigned SKIP_W = $clog2(LD_MAX_SKIP + 1);
    localparam int unsigned CNT_W  = $clog2(RD_LAT + 1);
    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(LD_MAX_SKIP);

    state_t            state;
    state_t            grant;
    logic [SKIP_W-1:0] skip;
    logic [CNT_W-1:0]  rd_cnt;
    logic              rd_busy;
    logic              stall;
    logic              vram_we;
    logic              oe;
    logic              next_oe;
    logic [15:0]       cpu_dout;
    mem_req_t          cmd;
    mem_req_t          next_cmd;
    logic              ld_full;
    logic              take;
    mem_req_t          ld_entry;

    ql_ld_buffer #(.LD_BASE(LD_BASE)) u_ld_buffer (
        .clk     (clk_sys),
        .reset   (reset),
        .ld_wr   (bus.ld_wr),
        .ld_addr (bus.ld_addr),
        .ld_data (bus.ld_data),
        .take    (take),
        .full    (ld_full),
        .entry   (ld_entry)
    );

    // The loader pre-empts the CPU only once it has lost LD_MAX_SKIP slots in a row.
    always_comb begin
        grant = IDLE;
        if (ld_full && skip == SKIP_MAX) grant = LD_WR;
        else if (bus.cpu_rd)             grant = CPU_RD;
        else if (bus.cpu_wr)             grant = CPU_WR;
        else if (ld_full)                grant = LD_WR;
    end

    always_comb begin
        next_cmd = '0;
        next_oe  = 1'b0;
        unique case (grant)
            CPU_RD: begin
                next_oe       = 1'b1;
                next_cmd.addr = bus.cpu_addr;
                next_cmd.ds   = bus.cpu_ds;
            end
            CPU_WR:  next_cmd = '{addr: bus.cpu_addr, data: bus.cpu_din, ds: bus.cpu_ds, we: 1'b1};
            LD_WR:   next_cmd = ld_entry;
            default: ;
        endcase
    end

    assign take = bus.slot && (grant == LD_WR);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= IDLE;
            skip     <= '0;
            rd_cnt   <= '0;
            rd_busy  <= 1'b0;
            stall    <= 1'b0;
            vram_we  <= 1'b0;
            oe       <= 1'b0;
            cmd      <= '0;
            cpu_dout <= '1;
        end else begin
            vram_we <= 1'b0;
            if (state == CPU_RD && rd_busy) begin
                if (rd_cnt == '0) begin
                    cpu_dout <= bus.sdram_dout;
                    rd_busy  <= 1'b0;
                    stall    <= 1'b0;
                end else begin
                    rd_cnt <= rd_cnt - 1'b1;
                end
            end
            if (bus.slot) begin
                state   <= grant;
                cmd     <= next_cmd;
                oe      <= next_oe;
                vram_we <= next_cmd.we && in_page(next_cmd.addr, VRAM_PAGE);
                unique case (grant)
                    CPU_RD:  stall <= 1'b1;
                    CPU_WR:  stall <= 1'b0;
                    default: stall <= bus.cpu_rd || bus.cpu_wr;
                endcase
                if (grant == CPU_RD) begin
                    rd_busy <= 1'b1;
                    rd_cnt  <= CNT_W'(RD_LAT - 1);
                end else begin
                    rd_busy <= 1'b0;
                end
                if (grant == LD_WR)
                    skip <= '0;
                else if (ld_full && (grant == CPU_RD || grant == CPU_WR) && skip != SKIP_MAX)
                    skip <= skip + 1'b1;
            end
        end
    end

    assign bus.sdram_addr = cmd.addr;
    assign bus.sdram_din  = cmd.data;
    assign bus.sdram_we   = cmd.we;
    assign bus.sdram_ds   = cmd.ds;
    assign bus.sdram_oe   = oe;
    assign bus.cpu_dout   = cpu_dout;
    assign bus.cpu_stall  = stall;
    assign bus.vram_we    = vram_we;
    assign bus.ld_wait    = ld_full;

endmodule

// File: tb/tb_ql_ram_arbiter.sv
// Scoreboard bench for ql_ram_arbiter: slot-level reference model, SDRAM memory model, monitor.
module tb_ql_ram_arbiter;

    localparam int RD_LAT = 6;
    localparam int MAX_SKIP = 4;
    localparam logic [23:0] LD_BASE = 24'h010000;
    localparam logic [8:0] VPAGE = 9'd2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ql_ram_arbiter_if bus ();

    ql_ram_arbiter #(
        .LD_BASE     (LD_BASE),
        .LD_MAX_SKIP (MAX_SKIP),
        .RD_LAT      (RD_LAT),
        .VRAM_PAGE   (VPAGE)
    ) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    // kind: 0 no access, 1 CPU read, 2 write (CPU or loader)
    typedef struct {
        int          kind;
        logic [23:0] addr;
        logic [15:0] data;
        logic [1:0]  ds;
        logic        vram;
        logic        stall;
        logic        ldwait;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] rd_q[$];
    logic [15:0] ref_mem[int];
    logic [15:0] sd_mem[int];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   age = 100;
    logic rst_seen = 1'b1;
    bit   mon_en = 1'b0;
    bit   rd_pend = 1'b0;
    int   rd_start = 0;

    bit          cpu_busy = 1'b0;
    int          cpu_kind = 0;
    int          cpu_drop = -1;
    logic [23:0] cpu_a = '0;
    logic [15:0] cpu_d = '0;
    logic [1:0]  cpu_s = '0;
    bit          pend = 1'b0;
    int          skip = 0;
    logic [23:0] buf_a = '0;
    logic [15:0] buf_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] ds);
        return {ds[1] ? nw[15:8] : old[15:8], ds[0] ? nw[7:0] : old[7:0]};
    endfunction

    function automatic logic [15:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'hA55A;
    endfunction

    function automatic logic [15:0] sd_rd(input logic [23:0] a);
        return sd_mem.exists(int'(a)) ? sd_mem[int'(a)] : 16'hA55A;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        age      <= bus.slot ? 0 : age + 1;
        rst_seen <= reset;
    end

    // SDRAM: writes land when a write command appears; read data is valid only on the capture edge.
    always @(negedge clk) begin
        if (age == 0 && bus.sdram_we)
            sd_mem[int'(bus.sdram_addr)] = merge(sd_rd(bus.sdram_addr), bus.sdram_din, bus.sdram_ds);
        bus.sdram_dout = (age == RD_LAT - 1 && bus.sdram_oe) ? sd_rd(bus.sdram_addr) : 16'hDEAD;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            rd_pend = 1'b0;
        end else if (mon_en) begin
            if (age == 0) begin
                if (rd_pend) begin
                    fail_now("rd_not_returned");
                    rd_pend = 1'b0;
                    if (rd_q.size() > 0) void'(rd_q.pop_front());
                end
                if (exp_q.size() == 0) begin
                    fail_now("scoreboard_underflow");
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_we", bus.sdram_we, e.kind == 2);
                    check("cmd_oe", bus.sdram_oe, e.kind == 1);
                    if (e.kind != 0) begin
                        check("cmd_addr", bus.sdram_addr, e.addr);
                        check("cmd_ds", bus.sdram_ds, e.ds);
                    end
                    if (e.kind == 2) check("cmd_din", bus.sdram_din, e.data);
                    check("vram_we", bus.vram_we, e.vram);
                    check("cpu_stall", bus.cpu_stall, e.stall);
                    check("ld_wait", bus.ld_wait, e.ldwait);
                    if (e.kind == 1) begin
                        rd_pend  = 1'b1;
                        rd_start = cyc;
                    end
                end
            end else begin
                check("vram_pulse_width", bus.vram_we, 1'b0);
                if (rd_pend && !bus.cpu_stall) begin
                    check("rd_latency", cyc - rd_start, RD_LAT);
                    if (rd_q.size() > 0) check("rd_data", bus.cpu_dout, rd_q.pop_front());
                    else fail_now("rd_queue_empty");
                    rd_pend = 1'b0;
                end else if (rd_pend && cyc - rd_start > RD_LAT + 2) begin
                    fail_now("rd_timeout");
                    rd_pend = 1'b0;
                    if (rd_q.size() > 0) void'(rd_q.pop_front());
                end
            end
        end
    end

    task automatic ld_capture(input logic [23:0] la, input logic [15:0] ld);
        if (!pend) begin
            pend  = 1'b1;
            buf_a = LD_BASE + la;
            buf_d = ld;
        end
    endtask

    // Predicts the access granted at a slot from the sharing rules and records it.
    task automatic predict();
        exp_t e;
        bit   was_full;
        int   g;
        was_full = pend;
        if (pend && skip == MAX_SKIP) g = 3;
        else if (cpu_busy)            g = cpu_kind;
        else if (pend)                g = 3;
        else                          g = 0;
        e.kind = (g == 3) ? 2 : g;
        e.addr = '0;
        e.data = '0;
        e.ds   = '0;
        if (g == 3) begin
            e.addr = buf_a;
            e.data = buf_d;
            e.ds   = 2'b11;
            skip   = 0;
            pend   = 1'b0;
        end else if (g != 0) begin
            e.addr = cpu_a;
            e.data = cpu_d;
            e.ds   = cpu_s;
            if (was_full && skip < MAX_SKIP) skip++;
            cpu_drop = (g == 1) ? 7 : 1;
        end
        if (g == 1) rd_q.push_back(ref_rd(cpu_a));
        if (e.kind == 2) ref_mem[int'(e.addr)] = merge(ref_rd(e.addr), e.data, e.ds);
        e.vram  = (e.kind == 2) && (e.addr[23:15] == VPAGE);
        e.stall = (g == 1) ? 1'b1 : (g == 2) ? 1'b0 : cpu_busy;
        if (bus.ld_wr && !was_full) ld_capture(bus.ld_addr, bus.ld_data);
        e.ldwait = pend;
        exp_q.push_back(e);
    endtask

    // One 8-cycle slot period; *_when give the cycle (0 = slot cycle) of each event, -1 = none.
    task automatic period(input int cw, input int ck, input logic [23:0] ca, input logic [15:0] cd,
                          input logic [1:0] cs, input int lw, input logic [23:0] la, input int lw2,
                          input int ra);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.slot  = (k == 0);
            bus.ld_wr = 1'b0;
            if (k == cpu_drop) begin
                bus.cpu_rd = 1'b0;
                bus.cpu_wr = 1'b0;
                cpu_busy   = 1'b0;
                cpu_drop   = -1;
            end
            if (k == cw && !cpu_busy) begin
                cpu_busy     = 1'b1;
                cpu_kind     = ck;
                cpu_a        = ca;
                cpu_d        = cd;
                cpu_s        = cs;
                bus.cpu_rd   = (ck == 1);
                bus.cpu_wr   = (ck == 2);
                bus.cpu_addr = ca;
                bus.cpu_din  = cd;
                bus.cpu_ds   = cs;
            end
            if (k == lw || k == lw2) begin
                bus.ld_wr   = 1'b1;
                bus.ld_addr = (k == lw) ? la : la + 24'd1;
                bus.ld_data = 16'($urandom);
            end
            if (k == ra) begin
                reset      = 1'b1;
                bus.ld_wr  = 1'b0;
                bus.cpu_rd = 1'b0;
                bus.cpu_wr = 1'b0;
                cpu_busy   = 1'b0;
                cpu_drop   = -1;
                pend       = 1'b0;
                skip       = 0;
                rd_q.delete();
            end else if (ra >= 0 && k == ra + 1) begin
                check("rst_sdram_we", bus.sdram_we, 1'b0);
                check("rst_sdram_oe", bus.sdram_oe, 1'b0);
                check("rst_ld_wait", bus.ld_wait, 1'b0);
                check("rst_vram_we", bus.vram_we, 1'b0);
                check("rst_cpu_dout", bus.cpu_dout, 16'hFFFF);
                check("rst_cpu_stall", bus.cpu_stall, 1'b0);
                reset = 1'b0;
            end
            if (k == 0) predict();
            else if (bus.ld_wr) ld_capture(bus.ld_addr, bus.ld_data);
        end
    endtask

    task automatic idle_period();
        period(-1, 0, '0, '0, '0, -1, '0, -1, -1);
    endtask

    function automatic logic [23:0] pick_addr(input int sel, input int off);
        logic [23:0] base[4];
        base = '{24'h000100, 24'h014000, 24'h010000, 24'h018000};
        return base[sel] + 24'(off);
    endfunction

    initial begin
        bus.slot = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0;
        bus.cpu_din = '0; bus.cpu_ds = '0; bus.ld_wr = 1'b0; bus.ld_addr = '0;
        bus.ld_data = '0; bus.sdram_dout = 16'hDEAD;
        repeat (3) @(negedge clk);
        check("init_cpu_dout", bus.cpu_dout, 16'hFFFF);
        check("init_cpu_stall", bus.cpu_stall, 1'b0);
        check("init_ld_wait", bus.ld_wait, 1'b0);
        check("init_sdram_addr", bus.sdram_addr, 24'h0);
        check("init_sdram_din", bus.sdram_din, 16'h0);
        check("init_sdram_we", bus.sdram_we, 1'b0);
        check("init_sdram_oe", bus.sdram_oe, 1'b0);
        check("init_sdram_ds", bus.sdram_ds, 2'b00);
        check("init_vram_we", bus.vram_we, 1'b0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // lone CPU read of unwritten RAM
        period(0, 1, 24'h000200, 16'h0, 2'b11, -1, '0, -1, -1);
        idle_period();
        // loader words 0..2 with the CPU idle
        for (int i = 0; i < 3; i++) period(-1, 0, '0, '0, '0, 2, 24'(i), -1, -1);
        idle_period();
        // CPU writing every slot while a loader word waits: loader wins after MAX_SKIP losses
        period(0, 2, 24'h000300, 16'h1111, 2'b11, 2, 24'h000005, -1, -1);
        for (int i = 1; i < 7; i++) period(0, 2, 24'h000300 + 24'(i), 16'(i), 2'b11, -1, '0, -1, -1);
        idle_period();
        // screen-window byte write, then read it back
        period(0, 2, 24'h014000, 16'h1234, 2'b01, -1, '0, -1, -1);
        period(0, 1, 24'h014000, 16'h0, 2'b11, -1, '0, -1, -1);
        // second loader word while the buffer is full is dropped
        period(-1, 0, '0, '0, '0, 2, 24'h000007, 5, -1);
        check("drop_ld_wait_held", bus.ld_wait, 1'b1);
        idle_period();
        // loader offset wrapping past 2^24
        period(-1, 0, '0, '0, '0, 3, 24'hFF0003, -1, -1);
        idle_period();

        for (int n = 0; n < 300; n++) begin
            int cw, lw, lw2;
            cw  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 7));
            lw  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 7));
            lw2 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
            period(cw, int'($urandom_range(1, 2)),
                   pick_addr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
                   16'($urandom), 2'($urandom_range(1, 3)),
                   lw, 24'($urandom_range(0, 3)), lw2, -1);
        end
        idle_period();
        idle_period();

        // reset while a loader write occupies the port
        period(-1, 0, '0, '0, '0, 2, 24'h000010, -1, -1);
        period(-1, 0, '0, '0, '0, -1, '0, -1, 1);
        idle_period();
        idle_period();

        check("scoreboard_drained", exp_q.size(), 0);
        check("read_queue_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
